// File: rtl/bench_host_port.sv
// Host-bus responder for the benchmark shell: word RAM, control/status registers
// and a checksum kernel that sums and XORs RAM[0..LEN-1].
module bench_host_port #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int RAM_WORDS  = 64
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  RD,
    input  logic                  WR,
    input  logic [ADDR_WIDTH-1:0] Addr,
    input  logic [DATA_WIDTH-1:0] DataIn,
    output logic [DATA_WIDTH-1:0] DataOut
);

    localparam int REG_BASE  = 2**ADDR_WIDTH - 8;
    localparam int LEN_W     = $clog2(RAM_WORDS + 1);
    localparam int RAM_IDX_W = $clog2(RAM_WORDS);

    localparam logic [ADDR_WIDTH-1:0] A_RAM_END = ADDR_WIDTH'(RAM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] A_CTRL    = ADDR_WIDTH'(REG_BASE + 0);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS  = ADDR_WIDTH'(REG_BASE + 1);
    localparam logic [ADDR_WIDTH-1:0] A_LEN     = ADDR_WIDTH'(REG_BASE + 2);
    localparam logic [ADDR_WIDTH-1:0] A_SUM     = ADDR_WIDTH'(REG_BASE + 3);
    localparam logic [ADDR_WIDTH-1:0] A_XOR     = ADDR_WIDTH'(REG_BASE + 4);
    localparam logic [ADDR_WIDTH-1:0] A_CYCLES  = ADDR_WIDTH'(REG_BASE + 5);
    localparam logic [DATA_WIDTH-1:0] LEN_MAX   = DATA_WIDTH'(RAM_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  ram [RAM_WORDS];
    logic [LEN_W-1:0]       len_q;
    logic [RAM_IDX_W-1:0]   idx_q;
    logic [DATA_WIDTH-1:0]  sum_q, xor_q, cycles_q;
    logic                   err_q;

    logic                   busy, ctrl_wr, start, abort, ram_wr, len_wr, err_set, last;
    logic [DATA_WIDTH-1:0]  ram_word, rd_data;

    assign busy     = (state_q == S_RUN);
    assign ctrl_wr  = WR && (Addr == A_CTRL);
    assign abort    = ctrl_wr && DataIn[1];
    assign start    = ctrl_wr && DataIn[0] && !DataIn[1];
    assign ram_wr   = WR && (Addr < A_RAM_END);
    assign len_wr   = WR && (Addr == A_LEN);
    assign err_set  = busy && (start || ram_wr || len_wr);
    assign last     = ({1'b0, idx_q} == (len_q - LEN_W'(1)));
    assign ram_word = ram[idx_q];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = (len_q == '0) ? S_DONE : S_RUN;
            S_RUN: begin
                if (abort)     state_d = S_IDLE;
                else if (last) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Host writes are locked out while the kernel walks the RAM.
    always_ff @(posedge Clk) begin
        if (ram_wr && !busy) ram[Addr[RAM_IDX_W-1:0]] <= DataIn;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            len_q    <= '0;
            idx_q    <= '0;
            sum_q    <= '0;
            xor_q    <= '0;
            cycles_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (len_wr && !busy)
                len_q <= (DataIn > LEN_MAX) ? LEN_W'(RAM_WORDS) : DataIn[LEN_W-1:0];
            if (start && !busy) begin
                idx_q    <= '0;
                sum_q    <= '0;
                xor_q    <= '0;
                cycles_q <= '0;
                err_q    <= 1'b0;
            end else begin
                // ABORT suppresses the accumulation of the cycle it lands in.
                if (busy && !abort) begin
                    sum_q    <= sum_q + ram_word;
                    xor_q    <= xor_q ^ ram_word;
                    cycles_q <= cycles_q + DATA_WIDTH'(1);
                    idx_q    <= idx_q + RAM_IDX_W'(1);
                end
                if (err_set) err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (Addr < A_RAM_END) begin
            rd_data = ram[Addr[RAM_IDX_W-1:0]];
        end else begin
            case (Addr)
                A_STATUS: rd_data = DATA_WIDTH'({err_q, state_q == S_DONE, busy});
                A_LEN:    rd_data = DATA_WIDTH'(len_q);
                A_SUM:    rd_data = sum_q;
                A_XOR:    rd_data = xor_q;
                A_CYCLES: rd_data = cycles_q;
                default:  rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)          DataOut <= '0;
        else if (RD && !WR)  DataOut <= rd_data;
        else                 DataOut <= '0;
    end

endmodule

// File: tb/tb_bench_host_port.sv
// Directed/randomized bench for bench_host_port with an array-based checksum model.
module tb_bench_host_port;

    localparam int RW = 64;
    localparam logic [7:0] RB = 8'hF8;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        RD = 1'b0;
    logic        WR = 1'b0;
    logic [7:0]  Addr = '0;
    logic [31:0] DataIn = '0;
    logic [31:0] DataOut;

    bench_host_port #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RAM_WORDS(RW)) dut (
        .Clk(Clk), .Reset(Reset), .RD(RD), .WR(WR),
        .Addr(Addr), .DataIn(DataIn), .DataOut(DataOut)
    );

    always #5 Clk = ~Clk;

    int          passed = 0;
    int          total = 0;
    logic [31:0] m_ram [RW];
    int          m_len;
    logic [31:0] v;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One vector period: drive away from the edge, sample 1 unit after it.
    task automatic drive(input logic r, input logic w, input logic [7:0] a, input logic [31:0] d);
        @(negedge Clk);
        RD = r; WR = w; Addr = a; DataIn = d;
        @(posedge Clk);
        #1;
        RD = 1'b0; WR = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        drive(1'b1, 1'b0, a, 32'h0);
        d = DataOut;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        drive(1'b0, 1'b1, a, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h0, 32'h0);
    endtask

    function automatic logic [31:0] m_sum(input int n);
        logic [31:0] s = 0;
        for (int i = 0; i < n; i++) s = s + m_ram[i];
        return s;
    endfunction

    function automatic logic [31:0] m_xor(input int n);
        logic [31:0] x = 0;
        for (int i = 0; i < n; i++) x = x ^ m_ram[i];
        return x;
    endfunction

    task automatic load(input int idx, input logic [31:0] d);
        m_ram[idx] = d;
        wr(8'(idx), d);
    endtask

    task automatic check_results(input string tag, input int n);
        logic [31:0] r;
        rd(RB + 8'd3, r); check({tag, "_sum"}, r, m_sum(n));
        rd(RB + 8'd4, r); check({tag, "_xor"}, r, m_xor(n));
        rd(RB + 8'd5, r); check({tag, "_cycles"}, r, 32'(n));
    endtask

    // START at edge n: BUSY seen at n+1..n+LEN, DONE at n+LEN+1.
    task automatic run_and_check(input string tag);
        logic [31:0] r;
        wr(RB, 32'h1);
        for (int i = 1; i <= m_len; i++) begin
            rd(RB + 8'd1, r); check({tag, "_busy"}, r, 32'h1);
        end
        rd(RB + 8'd1, r); check({tag, "_done"}, r, 32'h2);
        check_results(tag, m_len);
    endtask

    initial begin
        #3 Reset = 1'b0;
        #1 check("reset_dataout", DataOut, 32'h0);
        @(negedge Clk) Reset = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            rd(RB + 8'(k), v); check($sformatf("reset_reg%0d", k), v, 32'h0);
        end

        load(5, 32'hDEADBEEF);
        rd(8'd5, v); check("ram_rt", v, 32'hDEADBEEF);
        drive(1'b1, 1'b1, 8'd5, 32'h12345678);
        m_ram[5] = 32'h12345678;
        check("rdwr_out", DataOut, 32'h0);
        rd(8'd5, v); check("rdwr_write", v, 32'h12345678);
        rd(RB + 8'd6, v); check("unmapped", v, 32'h0);
        rd(RB, v); check("ctrl_read", v, 32'h0);

        load(0, 32'h1); load(1, 32'h2); load(2, 32'hFFFFFFFF); load(3, 32'h8);
        wr(RB + 8'd2, 32'd4); m_len = 4;
        run_and_check("csum");

        wr(RB + 8'd2, 32'd0);
        wr(RB, 32'h1);
        rd(RB + 8'd1, v); check("len0_done", v, 32'h2);
        check_results("len0", 0);

        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 8; i++) load(i, $urandom);
            m_len = $urandom_range(1, 8);
            wr(RB + 8'd2, 32'(m_len));
            run_and_check($sformatf("rand%0d", t));
        end

        for (int i = 0; i < 4; i++) load(i, $urandom);
        m_len = 4;
        wr(RB + 8'd2, 32'd4);
        wr(RB, 32'h1);
        wr(8'd0, ~m_ram[0]);
        wr(RB, 32'h1);
        idle(2);
        rd(RB + 8'd1, v); check("err_status", v, 32'h6);
        check_results("err", 4);
        rd(8'd0, v); check("err_ram_kept", v, m_ram[0]);
        wr(RB, 32'h1);
        rd(RB + 8'd1, v); check("err_cleared", v, 32'h1);
        idle(3);
        rd(RB + 8'd1, v); check("err_rerun_done", v, 32'h2);

        for (int i = 0; i < RW; i++) load(i, $urandom);
        wr(RB + 8'd2, 32'd1000);
        rd(RB + 8'd2, v); check("len_clamp", v, 32'd64);
        wr(RB, 32'h1);
        idle(10);
        wr(RB, 32'h3);
        rd(RB + 8'd1, v); check("abort_status", v, 32'h0);
        check_results("abort", 10);

        load(5, 32'hDEADBEEF);
        wr(RB, 32'h1);
        idle(3);
        rd(8'd5, v); check("busy_read", v, 32'hDEADBEEF);
        #2 Reset = 1'b0;
        #1 check("midrun_reset_out", DataOut, 32'h0);
        @(negedge Clk) Reset = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            rd(RB + 8'(k), v); check($sformatf("midrun_reg%0d", k), v, 32'h0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
